// File: rtl/ysyx_bus_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU bus arbiter.
// State encodings, response codes and requester IDs live here so the top and the bench agree.
package ysyx_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GNT_IFU    = 3'd1,
    ST_GNT_LSU_R  = 3'd2,
    ST_GNT_LSU_W  = 3'd3,
    ST_WAIT_IFU   = 3'd4,
    ST_WAIT_LSU_R = 3'd5,
    ST_WAIT_LSU_W = 3'd6
  } state_e;

  typedef enum logic {
    REQ_IFU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  function automatic logic is_wait(input state_e s);
    return (s == ST_WAIT_IFU) || (s == ST_WAIT_LSU_R) || (s == ST_WAIT_LSU_W);
  endfunction

endpackage

// File: rtl/ysyx_bus_arbiter_wdog.sv
// Response watchdog: counts cycles while enabled, flags expiry at all-ones.
// The count saturates so the flag stays up until the owner clears it.
module ysyx_bus_arbiter_wdog #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !(&cnt_q))
      cnt_d = cnt_q + TIMEOUT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired_o = en_i & (&cnt_q);

endmodule

// File: rtl/ysyx_bus_arbiter.sv
// Single-port bus arbiter between IFU (read) and LSU (read/write), one transaction in flight.
// Requests are muxed combinationally in GNT_*, responses routed back in WAIT_* with a watchdog.
module ysyx_bus_arbiter
  import ysyx_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  output logic [ADDR_W-1:0]   mem_araddr,
  output logic                mem_arvalid,
  input  logic                mem_arready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [1:0]          mem_rresp,
  input  logic                mem_rvalid,
  output logic [ADDR_W-1:0]   mem_awaddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_awvalid,
  input  logic                mem_awready,
  input  logic [1:0]          mem_bresp,
  input  logic                mem_bvalid
);

  state_e  state_q, state_d;
  req_id_e last_grant_q, last_grant_d;
  logic    wd_expired;
  logic    lsu_req;
  logic    ifu_timeout, lsu_r_timeout, lsu_b_timeout;

  assign lsu_req = lsu_arvalid | lsu_awvalid;

  ysyx_bus_arbiter_wdog #(.TIMEOUT_W(TIMEOUT_W)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!is_wait(state_q)),
    .en_i      (is_wait(state_q)),
    .expired_o (wd_expired)
  );

  // Resetting last_grant to LSU means the first contended IDLE cycle goes to the IFU.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ifu_arvalid && (last_grant_q == REQ_LSU || !lsu_req)) begin
          state_d      = ST_GNT_IFU;
          last_grant_d = REQ_IFU;
        end else if (lsu_awvalid) begin
          state_d      = ST_GNT_LSU_W;
          last_grant_d = REQ_LSU;
        end else if (lsu_arvalid) begin
          state_d      = ST_GNT_LSU_R;
          last_grant_d = REQ_LSU;
        end
      end
      ST_GNT_IFU: begin
        if (!ifu_arvalid)     state_d = ST_IDLE;
        else if (mem_arready) state_d = mem_rvalid ? ST_IDLE : ST_WAIT_IFU;
      end
      ST_GNT_LSU_R: begin
        if (!lsu_arvalid)     state_d = ST_IDLE;
        else if (mem_arready) state_d = mem_rvalid ? ST_IDLE : ST_WAIT_LSU_R;
      end
      ST_GNT_LSU_W: begin
        if (!lsu_awvalid)     state_d = ST_IDLE;
        else if (mem_awready) state_d = mem_bvalid ? ST_IDLE : ST_WAIT_LSU_W;
      end
      ST_WAIT_IFU, ST_WAIT_LSU_R: begin
        if (mem_rvalid || wd_expired) state_d = ST_IDLE;
      end
      ST_WAIT_LSU_W: begin
        if (mem_bvalid || wd_expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_LSU;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // A real response that coincides with expiry wins over the synthesized error.
  assign ifu_timeout   = (state_q == ST_WAIT_IFU)   & wd_expired & !mem_rvalid;
  assign lsu_r_timeout = (state_q == ST_WAIT_LSU_R) & wd_expired & !mem_rvalid;
  assign lsu_b_timeout = (state_q == ST_WAIT_LSU_W) & wd_expired & !mem_bvalid;

  always_comb begin
    mem_araddr  = '0;
    mem_arvalid = 1'b0;
    mem_awaddr  = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    mem_awvalid = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_bvalid  = 1'b0;
    unique case (state_q)
      ST_GNT_IFU: begin
        mem_araddr  = ifu_araddr;
        mem_arvalid = ifu_arvalid;
        ifu_rvalid  = ifu_arvalid & mem_arready & mem_rvalid;
      end
      ST_GNT_LSU_R: begin
        mem_araddr  = lsu_araddr;
        mem_arvalid = lsu_arvalid;
        lsu_rvalid  = lsu_arvalid & mem_arready & mem_rvalid;
      end
      ST_GNT_LSU_W: begin
        mem_awaddr  = lsu_awaddr;
        mem_wdata   = lsu_wdata;
        mem_wstrb   = lsu_wstrb;
        mem_awvalid = lsu_awvalid;
        lsu_bvalid  = lsu_awvalid & mem_awready & mem_bvalid;
      end
      ST_WAIT_IFU:   ifu_rvalid = mem_rvalid | wd_expired;
      ST_WAIT_LSU_R: lsu_rvalid = mem_rvalid | wd_expired;
      ST_WAIT_LSU_W: lsu_bvalid = mem_bvalid | wd_expired;
      default: ;
    endcase
  end

  assign ifu_rdata = ifu_timeout   ? '0       : mem_rdata;
  assign ifu_rresp = ifu_timeout   ? RESP_ERR : mem_rresp;
  assign lsu_rdata = lsu_r_timeout ? '0       : mem_rdata;
  assign lsu_rresp = lsu_r_timeout ? RESP_ERR : mem_rresp;
  assign lsu_bresp = lsu_b_timeout ? RESP_ERR : mem_bresp;

endmodule

// File: tb/tb_ysyx_bus_arbiter.sv
// Directed bench for ysyx_bus_arbiter: stimulus pushes expected responses,
// a negedge monitor pops them whenever a requester strobe appears.
module tb_ysyx_bus_arbiter;
  import ysyx_bus_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] K_IFU = 2'd0, K_LSU_R = 2'd1, K_LSU_B = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ifu_araddr, lsu_araddr, lsu_awaddr, mem_araddr, mem_awaddr;
  logic          ifu_arvalid, lsu_arvalid, lsu_awvalid;
  logic [DW-1:0] ifu_rdata, lsu_rdata, lsu_wdata, mem_rdata, mem_wdata;
  logic [1:0]    ifu_rresp, lsu_rresp, lsu_bresp, mem_rresp, mem_bresp;
  logic          ifu_rvalid, lsu_rvalid, lsu_bvalid;
  logic [DW/8-1:0] lsu_wstrb, mem_wstrb;
  logic          mem_arvalid, mem_arready, mem_rvalid;
  logic          mem_awvalid, mem_awready, mem_bvalid;

  always #5 clk = ~clk;

  ysyx_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid),
    .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid),
    .mem_awaddr(mem_awaddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
    .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid)
  );

  typedef struct packed {
    logic [1:0]    kind;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    logic [1:0]    k;
    logic [DW-1:0] d;
    logic [1:0]    r;
    if (rst && (ifu_rvalid || lsu_rvalid || lsu_bvalid)) begin
      chk("strobe_onehot", 64'($onehot({ifu_rvalid, lsu_rvalid, lsu_bvalid})), 64'd1);
      k = ifu_rvalid ? K_IFU : (lsu_rvalid ? K_LSU_R : K_LSU_B);
      d = ifu_rvalid ? ifu_rdata : (lsu_rvalid ? lsu_rdata : '0);
      r = ifu_rvalid ? ifu_rresp : (lsu_rvalid ? lsu_rresp : lsu_bresp);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: kind %0d data %0h resp %0h, none expected", k, d, r);
      end else begin
        e = sb.pop_front();
        chk("resp_kind", 64'(k), 64'(e.kind));
        chk("resp_data", 64'(d), 64'(e.data));
        chk("resp_code", 64'(r), 64'(e.resp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input bit is_w, output int n);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      n++;
      if (is_w ? mem_awvalid : mem_arvalid) return;
    end
    checks++;
    errors++;
    $display("FAIL bus_request_timeout: no %s valid within 50 cycles", is_w ? "aw" : "ar");
    n = -1;
  endtask

  task automatic drop(input logic [1:0] kind);
    if (kind == K_IFU) ifu_arvalid = 1'b0;
    else               lsu_arvalid = 1'b0;
  endtask

  // Slave side of one read; dly = cycles from handshake to response (0 = same cycle).
  task automatic serve_read(input string name, input logic [1:0] kind, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input int dly, output int lat);
    wait_req(1'b0, lat);
    if (lat < 0) return;
    chk({name, "_araddr"}, 64'(mem_araddr), 64'(addr));
    tick();
    mem_arready = 1'b1;
    if (dly == 0) begin
      sb.push_back('{kind, data, RESP_OKAY});
      mem_rvalid = 1'b1;
      mem_rdata  = data;
    end
    tick();
    mem_arready = 1'b0;
    if (dly > 0) begin
      repeat (dly - 1) tick();
      sb.push_back('{kind, data, RESP_OKAY});
      mem_rvalid = 1'b1;
      mem_rdata  = data;
      tick();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    drop(kind);
  endtask

  task automatic serve_write(input string name, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
    int lat;
    wait_req(1'b1, lat);
    if (lat < 0) return;
    chk({name, "_awaddr"}, 64'(mem_awaddr), 64'(addr));
    chk({name, "_wdata"},  64'(mem_wdata),  64'(data));
    chk({name, "_wstrb"},  64'(mem_wstrb),  64'(strb));
    tick();
    mem_awready = 1'b1;
    tick();
    mem_awready = 1'b0;
    sb.push_back('{K_LSU_B, '0, RESP_OKAY});
    mem_bvalid = 1'b1;
    tick();
    mem_bvalid  = 1'b0;
    lsu_awvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n;
    rst = 1'b0;
    ifu_araddr = '0; ifu_arvalid = 1'b0;
    lsu_araddr = '0; lsu_arvalid = 1'b0;
    lsu_awaddr = '0; lsu_awvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
    mem_arready = 1'b0; mem_rdata = '0; mem_rresp = '0; mem_rvalid = 1'b0;
    mem_awready = 1'b0; mem_bresp = '0; mem_bvalid = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_valids", 64'({mem_arvalid, mem_awvalid, ifu_rvalid, lsu_rvalid, lsu_bvalid}), 64'd0);
    chk("reset_bus", 64'({mem_araddr, mem_awaddr}), 64'd0);
    chk("reset_wbus", 64'({mem_wdata, mem_wstrb}), 64'd0);
    chk("reset_resp", 64'({ifu_rdata, ifu_rresp, lsu_rresp, lsu_bresp}), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // 1: IFU alone, response 3 cycles after accept
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
    serve_read("t1_ifu", K_IFU, 32'h8000_0000, 32'h0000_0413, 3, lat);
    chk("t1_ar_latency", 64'(lat), 64'd2);

    // 2: simultaneous reads after an IFU grant -> LSU, IFU, LSU, IFU
    ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_0200; lsu_arvalid = 1'b1;
    serve_read("t2_lsu_first", K_LSU_R, 32'h8000_0200, 32'h1111_2222, 2, lat);
    serve_read("t2_ifu_next", K_IFU, 32'h8000_0004, 32'h3333_4444, 0, lat);
    ifu_araddr = 32'h8000_0008; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_0204; lsu_arvalid = 1'b1;
    serve_read("t2_lsu_again", K_LSU_R, 32'h8000_0204, 32'h5555_6666, 1, lat);
    serve_read("t2_ifu_again", K_IFU, 32'h8000_0008, 32'h7777_8888, 1, lat);

    // 3: LSU write
    lsu_awaddr = 32'h8000_0100; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b0011; lsu_awvalid = 1'b1;
    serve_write("t3_write", 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011);
    chk("t3_wbus_idle", 64'({mem_awaddr, mem_wdata}), 64'd0);

    // 3b: last grant LSU, both pending -> IFU wins
    ifu_araddr = 32'h8000_000C; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_0208; lsu_arvalid = 1'b1;
    serve_read("t3b_ifu_first", K_IFU, 32'h8000_000C, 32'h0000_0093, 1, lat);
    serve_read("t3b_lsu_next", K_LSU_R, 32'h8000_0208, 32'hCAFE_F00D, 2, lat);

    // 4: slave never answers -> watchdog error, late response dropped
    lsu_araddr = 32'h8000_0300; lsu_arvalid = 1'b1;
    wait_req(1'b0, lat);
    tick();
    mem_arready = 1'b1;
    tick();
    mem_arready = 1'b0;
    sb.push_back('{K_LSU_R, '0, RESP_ERR});
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (lsu_rvalid) break;
    end
    chk("t4_timeout_seen", 64'(lsu_rvalid), 64'd1);
    chk("t4_timeout_cycles", 64'(n >= 255 && n <= 256), 64'd1);
    tick();
    lsu_arvalid = 1'b0;
    repeat (4) tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    chk("t4_late_dropped", 64'({ifu_rvalid, lsu_rvalid, lsu_bvalid}), 64'd0);
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;

    // 5: IFU withdraws in GNT_IFU; pending LSU granted next
    ifu_araddr = 32'h8000_0010; ifu_arvalid = 1'b1;
    wait_req(1'b0, lat);
    chk("t5_gnt_ifu_addr", 64'(mem_araddr), 64'h8000_0010);
    tick();
    ifu_arvalid = 1'b0;
    lsu_araddr = 32'h8000_0400; lsu_arvalid = 1'b1;
    #1;
    chk("t5_arvalid_drop", 64'(mem_arvalid), 64'd0);
    serve_read("t5_lsu", K_LSU_R, 32'h8000_0400, 32'hABCD_0123, 1, lat);
    chk("t5_regrant_latency", 64'(lat), 64'd3);

    // 6: reset during WAIT_LSU_W, then a clean IFU read
    lsu_awaddr = 32'h8000_0500; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'b1111; lsu_awvalid = 1'b1;
    wait_req(1'b1, lat);
    tick();
    mem_awready = 1'b1;
    tick();
    mem_awready = 1'b0;
    #2;
    rst = 1'b0;
    mem_bvalid = 1'b1;
    #1;
    chk("t6_reset_valids", 64'({mem_arvalid, mem_awvalid, ifu_rvalid, lsu_rvalid, lsu_bvalid}), 64'd0);
    chk("t6_reset_wbus", 64'({mem_awaddr, mem_wstrb}), 64'd0);
    lsu_awvalid = 1'b0;
    mem_bvalid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    ifu_araddr = 32'h8000_0020; ifu_arvalid = 1'b1;
    serve_read("t6_ifu_after", K_IFU, 32'h8000_0020, 32'h0010_0073, 1, lat);

    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
